// File: rtl/o_buf_ctrl_pkg.sv
// o_buf_ctrl_pkg: state encoding and mode constants shared by the output-buffer sequencer.
// Revision 1.0
`default_nettype none

package o_buf_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_WRITE   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam logic MODE_OS = 1'b1;
  localparam logic MODE_WS = 1'b0;

  // Counter must hold the longest phase length minus one (MAX_DEPTH+ARRAY_M-2).
  function automatic int phase_cnt_width(input int max_depth, input int array_m);
    return $clog2(max_depth + array_m);
  endfunction

endpackage

`default_nettype wire

// File: rtl/o_buf_phase_cnt.sv
// o_buf_phase_cnt: loadable down-counter with hold input and zero flag.
// Revision 1.0
`default_nettype none

module o_buf_phase_cnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             hold,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (!hold && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

`default_nettype wire

// File: rtl/o_buffer_ctrl.sv
// o_buffer_ctrl: job sequencer driving idx_gen_on / ag_o_on / drain for WS and OS jobs.
// Optional cycle counter enabled by O_BUF_CTRL_PERF_EN. Revision 1.0
`default_nettype none

module o_buffer_ctrl
  import o_buf_ctrl_pkg::*;
#(
  parameter int ARRAY_M   = 8,
  parameter int MAX_DEPTH = 8,
  parameter int RAM_SIZE  = 256,
  localparam int ADDR_WIDTH = $clog2(RAM_SIZE),
  localparam int DW         = $clog2(MAX_DEPTH) + 1,
  localparam int CW         = $clog2(ARRAY_M) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  cfg_mode,
  input  logic [DW-1:0]         cfg_depth,
  input  logic [CW-1:0]         cfg_num_cols,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic                  stall,
  output logic                  idx_gen_on,
  output logic                  ag_o_on,
  output logic                  drain,
  output logic                  mode,
  output logic [CW-1:0]         num_cols,
  output logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  output logic [31:0]           perf_cycles
);

  localparam int CNT_W = phase_cnt_width(MAX_DEPTH, ARRAY_M);

  state_t          state;
  logic [DW-1:0]   depth_q;
  logic [DW-1:0]   depth_clamp;
  logic [CW-1:0]   cols_clamp;
  logic            reject;
  logic            accept;
  logic            phase_end;
  logic            cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic [CNT_W-1:0] cnt_value;
  logic            cnt_zero;

  assign depth_clamp = (cfg_depth > DW'(MAX_DEPTH))  ? DW'(MAX_DEPTH) : cfg_depth;
  assign cols_clamp  = (cfg_num_cols > CW'(ARRAY_M)) ? CW'(ARRAY_M)   : cfg_num_cols;
  assign reject      = (depth_clamp == '0) || (cols_clamp == '0);
  assign accept      = (state == ST_IDLE) && start;
  assign phase_end   = !stall && cnt_zero;

  // Counter is loaded with phase length minus one; the final cycle is the one where it reads zero.
  always_comb begin
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    if (accept && !reject) begin
      cnt_load = 1'b1;
      if (cfg_mode == MODE_OS) begin
        cnt_load_val = CNT_W'(depth_clamp) - 1'b1;
      end else begin
        cnt_load_val = CNT_W'(depth_clamp) + CNT_W'(ARRAY_M - 2);
      end
    end else if ((state == ST_COLLECT) && phase_end) begin
      cnt_load     = 1'b1;
      cnt_load_val = CNT_W'(depth_q);
    end
  end

  o_buf_phase_cnt #(
    .WIDTH (CNT_W)
  ) u_phase_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .hold     (stall),
    .count    (cnt_value),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      depth_q   <= '0;
      mode      <= 1'b0;
      num_cols  <= '0;
      base_addr <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            depth_q   <= depth_clamp;
            mode      <= cfg_mode;
            num_cols  <= cols_clamp;
            base_addr <= cfg_base;
            busy      <= 1'b1;
            if (reject) begin
              state   <= ST_DONE;
              done    <= 1'b1;
              cfg_err <= 1'b1;
            end else if (cfg_mode == MODE_OS) begin
              state <= ST_WRITE;
            end else begin
              state <= ST_COLLECT;
            end
          end
        end
        ST_COLLECT: begin
          if (phase_end) state <= ST_DRAIN;
        end
        ST_DRAIN, ST_WRITE: begin
          if (phase_end) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          cfg_err <= 1'b0;
        end
        default: begin
          state   <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          cfg_err <= 1'b0;
        end
      endcase
    end
  end

  assign idx_gen_on = (state == ST_COLLECT) && !stall;
  assign ag_o_on    = ((state == ST_DRAIN) || (state == ST_WRITE)) && !stall;
  assign drain      = (state == ST_DRAIN) && !stall;

`ifdef O_BUF_CTRL_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_q <= '0;
    end else if (accept) begin
      perf_q <= '0;
    end else if (state != ST_IDLE) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_o_buffer_ctrl.sv
// tb_o_buffer_ctrl: directed jobs with a done-triggered scoreboard for o_buffer_ctrl.
// Revision 1.0
`default_nettype none

module tb_o_buffer_ctrl;

  localparam int AW = 8;
  localparam int DW = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          cfg_mode = 1'b0;
  logic [DW-1:0] cfg_depth = '0;
  logic [CW-1:0] cfg_num_cols = '0;
  logic [AW-1:0] cfg_base = '0;
  logic          stall = 1'b0;
  logic          idx_gen_on, ag_o_on, drain, mode, busy, done, cfg_err;
  logic [CW-1:0] num_cols;
  logic [AW-1:0] base_addr;
  logic [31:0]   perf_cycles;

  o_buffer_ctrl #(
    .ARRAY_M   (8),
    .MAX_DEPTH (8),
    .RAM_SIZE  (256)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .cfg_mode     (cfg_mode),
    .cfg_depth    (cfg_depth),
    .cfg_num_cols (cfg_num_cols),
    .cfg_base     (cfg_base),
    .stall        (stall),
    .idx_gen_on   (idx_gen_on),
    .ag_o_on      (ag_o_on),
    .drain        (drain),
    .mode         (mode),
    .num_cols     (num_cols),
    .base_addr    (base_addr),
    .busy         (busy),
    .done         (done),
    .cfg_err      (cfg_err),
    .perf_cycles  (perf_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   done_cyc;
    int   idx;
    int   ag;
    int   drn;
    logic err;
    logic mode;
    int   cols;
    int   base;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;
  int   timeouts = 0;
  logic fin = 1'b0;

  always @(posedge clk) edge_cnt++;

  // Monitor / scoreboard
  logic active = 1'b0;
  logic perf_pend = 1'b0;
  int   exp_perf = 0;
  int   acc_edge = 0;
  int   n_idx = 0, n_ag = 0, n_drn = 0;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (fin) begin
      chk("leftover_expectations", exp_q.size(), 0);
      chk("job_timeouts", timeouts, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end else if (!reset) begin
      if (active) begin
        exp_q.delete(0);
        active = 1'b0;
      end
      perf_pend = 1'b0;
      chk("reset_outputs_zero",
          int'(idx_gen_on | ag_o_on | drain | mode | busy | done | cfg_err |
               (|num_cols) | (|base_addr) | (|perf_cycles)), 0);
    end else begin
      if (perf_pend) begin
        chk("perf_cycles", int'(perf_cycles), exp_perf);
        perf_pend = 1'b0;
      end
      if (stall) chk("enables_during_stall", int'(idx_gen_on | ag_o_on | drain), 0);
      if (active) begin
        n_idx += int'(idx_gen_on);
        n_ag  += int'(ag_o_on);
        n_drn += int'(drain);
        if (done) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("done_cycle", edge_cnt - acc_edge, e.done_cyc);
          chk("idx_gen_on_cycles", n_idx, e.idx);
          chk("ag_o_on_cycles", n_ag, e.ag);
          chk("drain_cycles", n_drn, e.drn);
          chk("cfg_err", int'(cfg_err), int'(e.err));
          chk("mode", int'(mode), int'(e.mode));
          chk("num_cols", int'(num_cols), e.cols);
          chk("base_addr", int'(base_addr), e.base);
`ifdef O_BUF_CTRL_PERF_EN
          exp_perf = e.done_cyc;
`else
          exp_perf = 0;
`endif
          perf_pend = 1'b1;
          active = 1'b0;
        end
      end else if (done) begin
        chk("unexpected_done", 1, 0);
      end
      if (!active && !busy && start) begin
        acc_edge = edge_cnt;
        active = 1'b1;
        n_idx = 0;
        n_ag = 0;
        n_drn = 0;
      end
    end
  end

  // Driver: one job, optional stall window, stray start, and mid-job reset (cycle numbers from acceptance)
  task automatic run_job(input logic m, input int d, input int c, input int b,
                         input int st_at, input int st_len, input int xs_at,
                         input int rst_at, input exp_t e);
    int cyc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    start        = 1'b1;
    cfg_mode     = m;
    cfg_depth    = DW'(d);
    cfg_num_cols = CW'(c);
    cfg_base     = AW'(b);
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 1;
    while (busy && cyc < 200) begin
      stall = (cyc >= st_at) && (cyc < st_at + st_len);
      start = (cyc == xs_at);
      if (cyc == rst_at) reset = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (cyc >= 200) timeouts++;
    stall = 1'b0;
    start = 1'b0;
    reset = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    // WS D=8 cols=8 base=0x80
    run_job(1'b0, 8, 8, 'h80, 0, 0, 0, 0, '{25, 15, 9, 9, 1'b0, 1'b0, 8, 'h80});
    // OS D=8
    run_job(1'b1, 8, 8, 0, 0, 0, 0, 0, '{9, 0, 8, 0, 1'b0, 1'b1, 8, 0});
    // WS with 3-cycle stall mid-COLLECT
    run_job(1'b0, 8, 8, 'h11, 5, 3, 0, 0, '{28, 15, 9, 9, 1'b0, 1'b0, 8, 'h11});
    // rejected: depth 0, then cols 0
    run_job(1'b0, 0, 8, 'h22, 0, 0, 0, 0, '{1, 0, 0, 0, 1'b1, 1'b0, 8, 'h22});
    run_job(1'b1, 4, 0, 'h23, 0, 0, 0, 0, '{1, 0, 0, 0, 1'b1, 1'b1, 0, 'h23});
    // cols=12 clamps to 8; depth=15 clamps to 8
    run_job(1'b0, 3, 12, 'h10, 0, 0, 0, 0, '{15, 10, 4, 4, 1'b0, 1'b0, 8, 'h10});
    run_job(1'b1, 15, 5, 'hF0, 0, 0, 0, 0, '{9, 0, 8, 0, 1'b0, 1'b1, 5, 'hF0});
    // stray start during DRAIN (DRAIN covers cycles 10..12)
    run_job(1'b0, 2, 4, 5, 0, 0, 11, 0, '{13, 9, 3, 3, 1'b0, 1'b0, 4, 5});
    // reset mid-COLLECT: expectation is dropped by the monitor
    run_job(1'b0, 8, 8, 'h33, 0, 0, 0, 5, '{0, 0, 0, 0, 1'b0, 1'b0, 0, 0});
    run_job(1'b1, 3, 2, 7, 0, 0, 0, 0, '{4, 0, 3, 0, 1'b0, 1'b1, 2, 7});
    repeat (3) @(posedge clk);
    #1;
    fin = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_expired got timeout want summary");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
